// File: rtl/sqrt_arb_pkg.sv
// Shared configuration, tag type and round-robin helper for sqrt_arbiter.
// The optional SQRT_ARB_PERF_EN build adds performance counters to the top.
package sqrt_arb_pkg;

    localparam int NUM_REQ      = 4;
    localparam int WIDTH_INPUT  = 16;
    localparam int WIDTH_OUTPUT = WIDTH_INPUT / 2 + WIDTH_INPUT % 2;
    localparam int LATENCY      = WIDTH_OUTPUT;
    localparam int FIFO_DEPTH   = 2;

    localparam int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CREDIT_W = $clog2(FIFO_DEPTH + 1);

    typedef logic [ID_W-1:0] req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } tag_t;

    function automatic req_id_t rr_next(input req_id_t idx);
        return (idx == req_id_t'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
    endfunction

endpackage

// File: rtl/sqrt_result_fifo.sv
// Single-clock result FIFO; one instance per requester holds returned roots.
// The head is presented combinationally and reads as zero while empty.
module sqrt_result_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == CW'(DEPTH));
    assign do_pop     = pop_i && !empty_o;
    assign do_push    = push_i && (!full_o || do_pop);
    assign pop_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

    assign wr_ptr_d = do_push ? wrap_inc(wr_ptr_q) : wr_ptr_q;
    assign rd_ptr_d = do_pop  ? wrap_inc(rd_ptr_q) : rd_ptr_q;
    assign count_d  = count_q + CW'(do_push) - CW'(do_pop);

    // NOTE: storage is not reset; the counters alone define validity, and an
    // empty FIFO never exposes the stale contents.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/sqrt_arbiter.sv
// Round-robin sharing of one external pipelined square-root unit among NUM_REQ
// requesters with credit-protected result FIFOs. Optional macro: SQRT_ARB_PERF_EN.
module sqrt_arbiter
    import sqrt_arb_pkg::*;
(
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ*WIDTH_INPUT-1:0]  req_radicand,
    output logic [NUM_REQ-1:0]              rsp_valid,
    input  logic [NUM_REQ-1:0]              rsp_ready,
    output logic [NUM_REQ*WIDTH_OUTPUT-1:0] rsp_root,
    output logic                            sq_valid_in,
    output logic [WIDTH_INPUT-1:0]          sq_radicand,
`ifdef SQRT_ARB_PERF_EN
    output logic [31:0]                     perf_issue_count,
    output logic [31:0]                     perf_block_count,
`endif
    input  logic                            sq_valid_out,
    input  logic [WIDTH_OUTPUT-1:0]         sq_root
);

    logic [CREDIT_W-1:0] credit_q [NUM_REQ];
    logic [CREDIT_W-1:0] credit_d [NUM_REQ];
    req_id_t             ptr_q, ptr_d;
    tag_t                tag_q [LATENCY];
    tag_t                tail;

    logic [NUM_REQ-1:0]  eligible;
    logic                found, grant;
    req_id_t             cand, win_id;

    logic [NUM_REQ-1:0]  fifo_push, fifo_pop, fifo_empty, fifo_full;

    assign tail = tag_q[LATENCY-1];

    // NOTE: every combinational output gets a default before any branch so no
    // path leaves a value held, which would otherwise infer a latch.
    always_comb begin
        eligible    = '0;
        found       = 1'b0;
        win_id      = ptr_q;
        req_ready   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            eligible[k] = req_valid[k] && (credit_q[k] < CREDIT_W'(FIFO_DEPTH));
        end
        // NOTE: blocking assignments here are intentional: cand and found carry
        // the scan's running state from one iteration to the next.
        cand = rr_next(ptr_q);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && eligible[cand]) begin
                found  = 1'b1;
                win_id = cand;
            end
            cand = rr_next(cand);
        end
        // Gating with rst_n keeps every output low while reset is asserted.
        grant = found && rst_n;
        if (grant) req_ready[win_id] = 1'b1;
        sq_valid_in = grant;
        sq_radicand = grant ? req_radicand[win_id*WIDTH_INPUT +: WIDTH_INPUT] : '0;
        ptr_d       = grant ? win_id : ptr_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            credit_d[k] = credit_q[k] + CREDIT_W'(req_ready[k]) - CREDIT_W'(fifo_pop[k]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= req_id_t'(NUM_REQ - 1);
            for (int k = 0; k < NUM_REQ; k++) credit_q[k] <= '0;
            for (int s = 0; s < LATENCY; s++) tag_q[s] <= '0;
        end else begin
            ptr_q    <= ptr_d;
            credit_q <= credit_d;
            tag_q[0] <= '{valid: grant, id: win_id};
            for (int s = 1; s < LATENCY; s++) tag_q[s] <= tag_q[s-1];
        end
    end

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_req
        assign fifo_push[k] = sq_valid_out && tail.valid && (tail.id == req_id_t'(k));
        assign fifo_pop[k]  = rsp_ready[k] && !fifo_empty[k];
        assign rsp_valid[k] = !fifo_empty[k];

        sqrt_result_fifo #(
            .WIDTH (WIDTH_OUTPUT),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk         (clk),
            .rst_n       (rst_n),
            .push_i      (fifo_push[k]),
            .push_data_i (sq_root),
            .pop_i       (fifo_pop[k]),
            .pop_data_o  (rsp_root[k*WIDTH_OUTPUT +: WIDTH_OUTPUT]),
            .empty_o     (fifo_empty[k]),
            .full_o      (fifo_full[k])
        );
    end

    // A result with no matching issue means the root unit is out of step with the tag line.
    assert property (@(posedge clk) disable iff (!rst_n) sq_valid_out |-> tail.valid)
        else $error("sqrt_arbiter: sq_valid_out without an issued tag");
    assert property (@(posedge clk) disable iff (!rst_n)
                     (sq_valid_out && tail.valid) |-> (!fifo_full[tail.id] || fifo_pop[tail.id]))
        else $error("sqrt_arbiter: result returned to a full FIFO");

`ifdef SQRT_ARB_PERF_EN
    logic [31:0] perf_issue_q, perf_block_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issue_q <= '0;
            perf_block_q <= '0;
        end else begin
            if (grant) perf_issue_q <= perf_issue_q + 32'd1;
            if ((|req_valid) && !grant) perf_block_q <= perf_block_q + 32'd1;
        end
    end

    assign perf_issue_count = perf_issue_q;
    assign perf_block_count = perf_block_q;
`endif

endmodule

// File: tb/tb_sqrt_arbiter.sv
// Self-checking bench for sqrt_arbiter: directed scenarios plus random traffic
// against a transaction-level model; also covers the SQRT_ARB_PERF_EN build.
module tb_sqrt_arbiter;
    import sqrt_arb_pkg::*;

    logic                            clk = 1'b0;
    logic                            rst_n;
    logic [NUM_REQ-1:0]              req_valid, req_ready, rsp_valid, rsp_ready;
    logic [NUM_REQ*WIDTH_INPUT-1:0]  req_radicand;
    logic [NUM_REQ*WIDTH_OUTPUT-1:0] rsp_root;
    logic                            sq_valid_in, sq_valid_out;
    logic [WIDTH_INPUT-1:0]          sq_radicand;
    logic [WIDTH_OUTPUT-1:0]         sq_root;
`ifdef SQRT_ARB_PERF_EN
    logic [31:0]                     perf_issue_count, perf_block_count;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    sqrt_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_radicand (req_radicand),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_root     (rsp_root),
        .sq_valid_in  (sq_valid_in),
        .sq_radicand  (sq_radicand),
`ifdef SQRT_ARB_PERF_EN
        .perf_issue_count (perf_issue_count),
        .perf_block_count (perf_block_count),
`endif
        .sq_valid_out (sq_valid_out),
        .sq_root      (sq_root)
    );

    function automatic int isqrt(input int x);
        int r = 0;
        while ((r + 1) * (r + 1) <= x) r++;
        return r;
    endfunction

    // Stand-in for the external root unit: fixed LATENCY, shares rst_n.
    logic [LATENCY-1:0]      pipe_v;
    logic [WIDTH_OUTPUT-1:0] pipe_r [LATENCY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_v <= '0;
        end else begin
            pipe_v    <= (pipe_v << 1) | LATENCY'(sq_valid_in);
            pipe_r[0] <= WIDTH_OUTPUT'(isqrt(int'(sq_radicand)));
            for (int i = 1; i < LATENCY; i++) pipe_r[i] <= pipe_r[i-1];
        end
    end

    assign sq_valid_out = pipe_v[LATENCY-1];
    assign sq_root      = pipe_r[LATENCY-1];

    // Reference model: outstanding results per requester with the cycle they become visible.
    typedef struct {
        int t;
        int root;
    } pend_t;

    pend_t pend_q [NUM_REQ][$];
    int    credit_m [NUM_REQ];
    int    ptr_m, cyc, last_win, grants_m, blocks_m;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NUM_REQ; k++) begin
            pend_q[k].delete();
            credit_m[k] = 0;
        end
        ptr_m    = NUM_REQ - 1;
        last_win = -1;
        grants_m = 0;
        blocks_m = 0;
    endtask

    task automatic set_rad(input int k, input logic [WIDTH_INPUT-1:0] v);
        req_radicand[k*WIDTH_INPUT +: WIDTH_INPUT] = v;
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic cycle();
        logic [NUM_REQ-1:0]     exp_ready, exp_rv;
        logic [WIDTH_INPUT-1:0] rad;
        int                     win, k;
        pend_t                  p;
        #2;
        win = -1;
        for (int i = 1; i <= NUM_REQ; i++) begin
            k = (ptr_m + i) % NUM_REQ;
            if (win < 0 && req_valid[k] && credit_m[k] < FIFO_DEPTH) win = k;
        end
        exp_ready = '0;
        if (win >= 0) exp_ready[win] = 1'b1;
        rad = (win >= 0) ? req_radicand[win*WIDTH_INPUT +: WIDTH_INPUT] : '0;
        check("req_ready", req_ready, exp_ready);
        check("sq_valid_in", sq_valid_in, win >= 0);
        check("sq_radicand", sq_radicand, rad);
        exp_rv = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (pend_q[j].size() > 0) exp_rv[j] = (pend_q[j][0].t <= cyc);
        end
        check("rsp_valid", rsp_valid, exp_rv);
        for (int j = 0; j < NUM_REQ; j++) begin
            if (exp_rv[j]) check($sformatf("rsp_root[%0d]", j),
                                 rsp_root[j*WIDTH_OUTPUT +: WIDTH_OUTPUT], pend_q[j][0].root);
        end
        last_win = win;
        if (win >= 0) grants_m++;
        else if (|req_valid) blocks_m++;
        @(posedge clk);
        if (win >= 0) begin
            credit_m[win]++;
            ptr_m  = win;
            p.t    = cyc + LATENCY + 1;
            p.root = isqrt(int'(rad));
            pend_q[win].push_back(p);
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (exp_rv[j] && rsp_ready[j]) begin
                credit_m[j]--;
                void'(pend_q[j].pop_front());
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain(input int n);
        req_valid = '0;
        rsp_ready = '1;
        repeat (n) cycle();
    endtask

    initial begin
        int n, g;
        cyc          = 0;
        req_valid    = '0;
        rsp_ready    = '0;
        req_radicand = '0;
        model_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;

        // Outputs stay low under reset even with requests pending.
        req_valid = '1;
        #11;
        check("reset req_ready", req_ready, '0);
        check("reset sq_valid_in", sq_valid_in, 1'b0);
        check("reset sq_radicand", sq_radicand, '0);
        check("reset rsp_valid", rsp_valid, '0);
        check("reset rsp_root", rsp_root, '0);
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // All requesters valid: round-robin starting at requester 0.
        set_rad(0, 16'd0);
        set_rad(1, 16'd1);
        set_rad(2, 16'd65535);
        set_rad(3, 16'd4095);
        req_valid = '1;
        rsp_ready = '1;
        for (int i = 0; i < 8; i++) begin
            cycle();
            check($sformatf("rr grant %0d", i), last_win, i % NUM_REQ);
        end
        repeat (30) cycle();
        drain(20);

        // Single request: root appears LATENCY+1 cycles later, only at requester 0.
        set_rad(0, 16'd144);
        req_valid = 4'b0001;
        rsp_ready = '0;
        cycle();
        check("single grant", last_win, 0);
        req_valid = '0;
        n = 1;
        while (!rsp_valid[0] && n < 30) begin
            cycle();
            n++;
        end
        check("single latency", n, LATENCY + 1);
        check("single root", rsp_root[0 +: WIDTH_OUTPUT], 12);
        check("single others idle", rsp_valid & 4'b1110, '0);
        drain(3);

        // Back-pressure on requester 1: credits cap its grants at FIFO_DEPTH.
        req_valid = '1;
        rsp_ready = 4'b1101;
        g = 0;
        repeat (40) begin
            cycle();
            if (last_win == 1) g++;
        end
        check("bp grants req1", g, FIFO_DEPTH);
        check("bp req_ready1", req_ready[1], 1'b0);
        rsp_ready[1] = 1'b1;
        cycle();
        rsp_ready[1] = 1'b0;
        g = 0;
        repeat (30) begin
            cycle();
            if (last_win == 1) g++;
        end
        check("bp one more req1", g, 1);
        drain(25);

        // Requester 2 at full credit: same-cycle pop does not enable a grant.
        set_rad(2, 16'd10000);
        req_valid = 4'b0100;
        rsp_ready = '0;
        repeat (14) cycle();
        check("full fifo rsp_valid2", rsp_valid[2], 1'b1);
        rsp_ready[2] = 1'b1;
        cycle();
        check("pop at full credit no grant", last_win, -1);
        cycle();
        check("grant after pop", last_win, 2);
        rsp_ready[2] = 1'b0;
        cycle();
        check("issue+pop keeps credit", last_win, 2);
        cycle();
        check("credit exhausted again", last_win, -1);
        drain(25);

        // Random traffic, including the extreme radicands.
        for (int c = 0; c < 400; c++) begin
            req_valid = NUM_REQ'($urandom);
            rsp_ready = NUM_REQ'($urandom);
            for (int k = 0; k < NUM_REQ; k++) begin
                case ($urandom_range(0, 5))
                    0:       set_rad(k, '1);
                    1:       set_rad(k, '0);
                    default: set_rad(k, WIDTH_INPUT'($urandom));
                endcase
            end
            cycle();
        end
        drain(25);

`ifdef SQRT_ARB_PERF_EN
        check("perf_issue_count", perf_issue_count, grants_m);
        check("perf_block_count", perf_block_count, blocks_m);
`endif

        // Reset with three requests in flight.
        set_rad(0, 16'd81);
        set_rad(1, 16'd400);
        set_rad(2, 16'd900);
        set_rad(3, 16'd49);
        req_valid = 4'b0111;
        rsp_ready = '1;
        repeat (3) cycle();
        #2 rst_n = 1'b0;
        #1;
        check("midrst req_ready", req_ready, '0);
        check("midrst sq_valid_in", sq_valid_in, 1'b0);
        check("midrst sq_radicand", sq_radicand, '0);
        check("midrst rsp_valid", rsp_valid, '0);
        check("midrst rsp_root", rsp_root, '0);
        model_reset();
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = 4'b1000;
        cycle();
        check("post-reset req3 first", last_win, 3);
        req_valid = '1;
        cycle();
        check("post-reset then req0", last_win, 0);
        drain(20);

`ifdef SQRT_ARB_PERF_EN
        check("perf_issue after reset", perf_issue_count, grants_m);
        check("perf_block after reset", perf_block_count, blocks_m);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/sqrt_arbiter.md
Name: sqrt_arbiter

Overview:
- Shares one pipelined unsigned integer square-root unit among NUM_REQ requesters.
- Round-robin picks at most one request per cycle and issues it to the root pipeline.
- Tags each issue with the requester ID through a delay line matched to the pipeline latency, then steers the root into that requester's result FIFO.
- Per-requester credit counting ensures a result never arrives to a full FIFO, since the root pipeline cannot stall.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- WIDTH_INPUT, 16, radicand width.
- WIDTH_OUTPUT, WIDTH_INPUT/2 + WIDTH_INPUT%2, root width.
- LATENCY, WIDTH_OUTPUT, cycles from sq_valid_in to sq_valid_out of the attached root unit.
- FIFO_DEPTH, 2, result FIFO entries per requester (power of two, >=1).

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept; a transfer occurs when valid&ready.
- req_radicand  input  NUM_REQ*WIDTH_INPUT  packed radicands; requester k occupies bits [k*WIDTH_INPUT +: WIDTH_INPUT].
- rsp_valid  output  NUM_REQ  result available.
- rsp_ready  input  NUM_REQ  result consumed when valid&ready.
- rsp_root  output  NUM_REQ*WIDTH_OUTPUT  packed roots, head of each FIFO.
- sq_valid_in  output  1  issue strobe to root unit.
- sq_radicand  output  WIDTH_INPUT  radicand to root unit.
- sq_valid_out  input  1  root unit output valid.
- sq_root  input  WIDTH_OUTPUT  root unit result.

Behaviour:
- Reset: clk is the single clock; rst_n is asynchronous and active-low.
  - All outputs 0; FIFOs empty; credit counters 0; tag line cleared.
  - RR pointer = NUM_REQ-1, so requester 0 has first priority.
- Eligibility: requester k is eligible when req_valid[k] && credit[k] < FIFO_DEPTH.
  - credit[k] = issued-not-yet-returned + FIFO occupancy.
- Arbitration: scan starts at pointer+1 modulo NUM_REQ; the first eligible requester wins.
  - req_ready is one-hot or zero, combinational from req_valid and registered state.
  - req_ready[k] never asserts without req_valid[k].
  - The pointer updates to the winner only on a grant; it holds otherwise.
- Issue: in the grant cycle, sq_valid_in=1 and sq_radicand=the winner's radicand (combinational, zero latency).
  - The winner ID and a valid bit enter the LATENCY-deep tag shift register.
  - credit[winner] increments.
- Return: when sq_valid_out=1, the tag at the tail of the shift register must be valid.
  - sq_root is written into FIFO[tag ID].
  - A sq_valid_out with an invalid tag is a protocol error: ignored, with a sim-only $error.
- Pop: rsp_valid[k] = FIFO[k] non-empty; rsp_root shows the head.
  - rsp_valid&rsp_ready pops the head and decrements credit[k].
- Simultaneous events:
  - Issue and pop on the same k in one cycle: credit unchanged.
  - Write and pop on the same FIFO in one cycle are both performed; pop on an empty FIFO is ignored.
- Throughput: one issue per cycle sustained when credits allow. Minimum request-to-rsp_valid latency is LATENCY+1 cycles (one FIFO write cycle).
- Credit boundary: credit saturates at FIFO_DEPTH by construction; overflow is impossible. The counter is $clog2(FIFO_DEPTH+1) bits.
- Reset mid-operation clears in-flight tags; the root unit must share the same rst_n.

Optional Feature:
- Macro: SQRT_ARB_PERF_EN.
- Defined: adds output ports perf_issue_count and perf_block_count, each 32 bits, reset 0, wrapping.
  - perf_issue_count increments on every grant.
  - perf_block_count increments on every cycle where some req_valid is high but no grant occurs (all credits exhausted).
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package sqrt_arb_pkg holds:
  - ID_W = $clog2(NUM_REQ) (minimum 1).
  - CREDIT_W.
  - Tag struct {valid, id}.
  - RR next-index function.
- Sub-module sqrt_result_fifo: single-clock, WIDTH_OUTPUT x FIFO_DEPTH, push/pop/empty/full, asynchronous active-low reset; instantiated NUM_REQ times.
- The tag delay line is inline and the root unit stays external.

Test Plan:
- Single request: req0 radicand 144 -> rsp_valid[0] after LATENCY+1 cycles, rsp_root=12; other rsp_valid stay 0.
- All four requesters valid continuously with radicands 0, 1, 65535, 4095 -> grants 0,1,2,3,0,…; returned roots 0, 1, 255, 63 each to the correct requester.
- Back-pressure, FIFO_DEPTH=2, rsp_ready[1]=0, req1 always valid -> exactly 2 grants to req1, then req_ready[1]=0. Other requesters keep one grant per cycle. Raising rsp_ready[1] for one cycle allows one more req1 grant.
- Same-cycle pop and issue on requester 2 with credit=2 -> no grant that cycle (credit checked pre-update); the grant follows next cycle.
- Assert rst_n low with 3 requests in flight -> all outputs 0 asynchronously. After release, req3 issues first only if req0..2 are idle; no stale rsp_valid.
- With SQRT_ARB_PERF_EN: 10 grants plus 5 fully blocked cycles -> perf_issue_count=10, perf_block_count=5.
